// File: rtl/car_game_pkg.sv
// car_game_pkg: state encoding, screen/road geometry and coordinate widths
// shared by the car motion, sprite and collision blocks.
package car_game_pkg;
    typedef enum logic [1:0] {IDLE, RUN, MOVE, CRASH} state_e;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int SCREEN_H   = 480;
    localparam int ROAD_LEFT  = 200;
    localparam int ROAD_RIGHT = 440;
endpackage

// File: rtl/axis_step_clamp.sv
// axis_step_clamp: one-axis position step by STEP, clamped to [min_i, max_i];
// opposing or absent requests leave the position unchanged.
module axis_step_clamp #(
    parameter int W    = 10,
    parameter int STEP = 2
) (
    input  logic [W-1:0] pos_i,
    input  logic         dec_i,
    input  logic         inc_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] pos_o
);
    localparam logic signed [10:0] S = 11'(STEP);
    logic signed [10:0] p, lo, hi;
    assign p  = 11'(pos_i);
    assign lo = 11'(min_i);
    assign hi = 11'(max_i);
    // The arithmetic result is only taken after the 11-bit signed guard, so it never wraps
    assign pos_o = (dec_i == inc_i) ? pos_i
                 : dec_i ? ((p - S < lo) ? min_i : pos_i - W'(STEP))
                 : ((p + S > hi) ? max_i : pos_i + W'(STEP));
endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: per-frame car position controller with road clamping,
// a blink-then-respawn crash sequence and a sprite visibility gate.
module car_motion_ctrl
    import car_game_pkg::*;
#(
    parameter int CAR_W        = 17,
    parameter int CAR_H        = 34,
    parameter int START_X      = 312,
    parameter int START_Y      = 420,
    parameter int STEP         = 2,
    parameter int FRAME_DIV    = 1,
    parameter int CRASH_FRAMES = 60,
    parameter int BLINK_FRAMES = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           frame_tick,
    input  logic           enable,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           crash,
    output logic [X_W-1:0] car_x,
    output logic [Y_W-1:0] car_y,
    output logic           visible,
    output logic           update_done,
    output logic           in_crash
);
    localparam int CW = $clog2(CRASH_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    state_e         state_q, state_d;
    logic [X_W-1:0] x_q, x_d, x_nxt;
    logic [Y_W-1:0] y_q, y_d, y_nxt;
    logic           vis_q, vis_d, done_q, done_d, inc_q, inc_d, pend_q, pend_d;
    logic [3:0]     div_q, div_d, btn_q, btn_d;
    logic [CW-1:0]  ccnt_q, ccnt_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic           go_crash, div_last, crash_last, blink_last;
    assign go_crash   = crash | pend_q;
    assign div_last   = div_q == 4'(FRAME_DIV - 1);
    assign crash_last = ccnt_q == CW'(CRASH_FRAMES - 1);
    assign blink_last = bcnt_q == BW'(BLINK_FRAMES - 1);
    assign car_x       = x_q;
    assign car_y       = y_q;
    assign visible     = vis_q;
    assign update_done = done_q;
    assign in_crash    = inc_q;
    // btn_q order: {left, right, up, down}
    axis_step_clamp #(.W(X_W), .STEP(STEP)) u_x (
        .pos_i(x_q), .dec_i(btn_q[3]), .inc_i(btn_q[2]),
        .min_i(X_W'(ROAD_LEFT)), .max_i(X_W'(ROAD_RIGHT - CAR_W)), .pos_o(x_nxt)
    );
    axis_step_clamp #(.W(Y_W), .STEP(STEP)) u_y (
        .pos_i(y_q), .dec_i(btn_q[1]), .inc_i(btn_q[0]),
        .min_i('0), .max_i(Y_W'(SCREEN_H - CAR_H)), .pos_o(y_nxt)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= X_W'(START_X);
            y_q     <= Y_W'(START_Y);
            vis_q   <= 1'b0;
            done_q  <= 1'b0;
            inc_q   <= 1'b0;
            pend_q  <= 1'b0;
            div_q   <= '0;
            btn_q   <= '0;
            ccnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            done_q  <= done_d;
            inc_q   <= inc_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            btn_q   <= btn_d;
            ccnt_q  <= ccnt_d;
            bcnt_q  <= bcnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = enable ? RUN : IDLE;
            RUN:   state_d = !enable ? IDLE : go_crash ? CRASH : (frame_tick && div_last) ? MOVE : RUN;
            MOVE:  state_d = RUN;
            CRASH: state_d = !enable ? IDLE : (frame_tick && crash_last) ? RUN : CRASH;
        endcase
    end
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vis_d  = vis_q;
        done_d = 1'b0;
        inc_d  = inc_q;
        pend_d = pend_q;
        div_d  = div_q;
        btn_d  = btn_q;
        ccnt_d = ccnt_q;
        bcnt_d = bcnt_q;
        case (state_q)
            IDLE: begin
                vis_d  = enable;
                inc_d  = 1'b0;
                pend_d = 1'b0;
                if (enable) begin
                    x_d   = X_W'(START_X);
                    y_d   = Y_W'(START_Y);
                    div_d = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    vis_d  = 1'b0;
                    pend_d = 1'b0;
                end else if (go_crash) begin
                    inc_d  = 1'b1;
                    pend_d = 1'b0;
                    ccnt_d = '0;
                    bcnt_d = '0;
                end else if (frame_tick) begin
                    div_d = div_last ? 4'd0 : div_q + 4'd1;
                    btn_d = div_last ? {btn_left, btn_right, btn_up, btn_down} : btn_q;
                end
            end
            MOVE: begin
                x_d    = x_nxt;
                y_d    = y_nxt;
                done_d = 1'b1;
                pend_d = crash;
            end
            CRASH: begin
                if (!enable) begin
                    inc_d = 1'b0;
                    vis_d = 1'b0;
                end else if (frame_tick && crash_last) begin
                    x_d   = X_W'(START_X);
                    y_d   = Y_W'(START_Y);
                    vis_d = 1'b1;
                    inc_d = 1'b0;
                    div_d = '0;
                end else if (frame_tick) begin
                    ccnt_d = ccnt_q + CW'(1);
                    bcnt_d = blink_last ? '0 : bcnt_q + BW'(1);
                    vis_d  = blink_last ? !vis_q : vis_q;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl: table-driven motion vectors with a position scoreboard,
// plus crash, abort, reset and frame-divider sequences.
module tb_car_motion_ctrl;
    logic       CLK = 0, RST = 1;
    logic       frame_tick = 0, enable = 0, crash = 0;
    logic       btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
    logic [9:0] car_x, x1;
    logic [8:0] car_y, y1;
    logic       visible, update_done, in_crash, vis1, upd1, inc1;
    typedef struct { int x; int y; } pos_t;
    typedef struct { logic [3:0] btn; int ticks; int ex; int ey; } vec_t;
    pos_t sbq[$];
    vec_t tbl[9];
    int   total = 0, passed = 0, d0_done = 0, d1_done = 0, mx = 312, my = 420;
    bit   run_model = 0;
    always #5 CLK = ~CLK;
    car_motion_ctrl dut (
        .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .crash(crash), .car_x(car_x), .car_y(car_y), .visible(visible),
        .update_done(update_done), .in_crash(in_crash)
    );
    car_motion_ctrl #(.FRAME_DIV(3)) dut_div (
        .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .crash(crash), .car_x(x1), .car_y(y1), .visible(vis1),
        .update_done(upd1), .in_crash(inc1)
    );
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    function automatic int step(input int p, input bit dec, input bit inc, input int lo, input int hi);
        if (dec && !inc) return (p - 2 < lo) ? lo : p - 2;
        if (inc && !dec) return (p + 2 > hi) ? hi : p + 2;
        return p;
    endfunction
    task automatic tick(input bit c);
        @(negedge CLK);
        frame_tick = 1;
        crash = c;
        if (run_model && !c) begin
            mx = step(mx, btn_left, btn_right, 200, 423);
            my = step(my, btn_up, btn_down, 0, 446);
            sbq.push_back('{mx, my});
        end
        @(negedge CLK);
        frame_tick = 0;
        crash = 0;
        repeat (3) @(negedge CLK);
    endtask
    always @(negedge CLK) begin : mon
        pos_t e;
        if (update_done) begin
            d0_done++;
            if (sbq.size() == 0) chk("sb_spurious_update", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("sb_x", int'(car_x), e.x);
                chk("sb_y", int'(car_y), e.y);
            end
        end
        if (upd1) d1_done++;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{4'b0100,   5, 322, 420};
        tbl[1] = '{4'b0100,  51, 423, 420};
        tbl[2] = '{4'b1000, 101, 221, 420};
        tbl[3] = '{4'b1000,  20, 200, 420};
        tbl[4] = '{4'b0001,  12, 200, 444};
        tbl[5] = '{4'b1101,   1, 200, 446};
        tbl[6] = '{4'b0001,   3, 200, 446};
        tbl[7] = '{4'b0111,   1, 202, 446};
        tbl[8] = '{4'b1010,   2, 200, 442};
        repeat (3) @(negedge CLK);
        chk("rst_x", int'(car_x), 312);
        chk("rst_y", int'(car_y), 420);
        chk("rst_visible", int'(visible), 0);
        chk("rst_update_done", int'(update_done), 0);
        chk("rst_in_crash", int'(in_crash), 0);
        RST = 0;
        btn_right = 1;
        tick(0);
        chk("idle_hold_x", int'(car_x), 312);
        enable = 1;
        @(negedge CLK);
        chk("enable_visible", int'(visible), 1);
        run_model = 1;
        for (int i = 0; i < 9; i++) begin
            {btn_left, btn_right, btn_up, btn_down} = tbl[i].btn;
            d0_done = 0;
            repeat (tbl[i].ticks) tick(0);
            chk($sformatf("vec%0d_x", i), int'(car_x), tbl[i].ex);
            chk($sformatf("vec%0d_y", i), int'(car_y), tbl[i].ey);
            chk($sformatf("vec%0d_updates", i), d0_done, tbl[i].ticks);
        end
        // crash on the same cycle as a tick: no move, then blink and respawn
        {btn_left, btn_right, btn_up, btn_down} = 4'b0100;
        run_model = 0;
        tick(1);
        chk("crash_in", int'(in_crash), 1);
        chk("crash_vis", int'(visible), 1);
        chk("crash_x", int'(car_x), 200);
        chk("crash_y", int'(car_y), 442);
        for (int k = 1; k <= 60; k++) begin
            tick(k == 10);
            if (k < 60) begin
                chk($sformatf("blink_vis_t%0d", k), int'(visible), ((k / 6) % 2 == 0) ? 1 : 0);
                chk($sformatf("blink_in_t%0d", k), int'(in_crash), 1);
                chk($sformatf("blink_x_t%0d", k), int'(car_x), 200);
            end
        end
        chk("respawn_x", int'(car_x), 312);
        chk("respawn_y", int'(car_y), 420);
        chk("respawn_vis", int'(visible), 1);
        chk("respawn_in", int'(in_crash), 0);
        mx = 312;
        my = 420;
        run_model = 1;
        // crash during the MOVE cycle is held and taken on the following RUN cycle
        @(negedge CLK);
        frame_tick = 1;
        mx = 314;
        sbq.push_back('{mx, my});
        @(negedge CLK);
        frame_tick = 0;
        crash = 1;
        @(negedge CLK);
        crash = 0;
        @(negedge CLK);
        chk("pend_in_crash", int'(in_crash), 1);
        chk("pend_x", int'(car_x), 314);
        btn_right = 0;
        run_model = 0;
        enable = 0;
        @(negedge CLK);
        chk("abort_in", int'(in_crash), 0);
        chk("abort_vis", int'(visible), 0);
        chk("abort_x", int'(car_x), 314);
        tick(0);
        enable = 1;
        @(negedge CLK);
        chk("reen_vis", int'(visible), 1);
        chk("reen_x", int'(car_x), 312);
        chk("reen_in", int'(in_crash), 0);
        mx = 312;
        my = 420;
        run_model = 1;
        // asynchronous reset in the middle of a crash
        btn_right = 1;
        repeat (2) tick(0);
        btn_right = 0;
        run_model = 0;
        tick(1);
        repeat (30) tick(0);
        chk("mid_vis_t30", int'(visible), 0);
        chk("mid_in_t30", int'(in_crash), 1);
        chk("mid_x_t30", int'(car_x), 316);
        #2 RST = 1;
        #1;
        chk("arst_x", int'(car_x), 312);
        chk("arst_y", int'(car_y), 420);
        chk("arst_vis", int'(visible), 0);
        chk("arst_in", int'(in_crash), 0);
        enable = 0;
        @(negedge CLK);
        RST = 0;
        tick(0);
        chk("post_rst_vis", int'(visible), 0);
        chk("post_rst_in", int'(in_crash), 0);
        // frame divider of 3 on the second instance
        d0_done = 0;
        d1_done = 0;
        btn_up = 1;
        enable = 1;
        @(negedge CLK);
        mx = 312;
        my = 420;
        run_model = 1;
        repeat (6) tick(0);
        chk("div3_updates", d1_done, 2);
        chk("div3_y", int'(y1), 416);
        chk("div3_x", int'(x1), 312);
        chk("div1_updates", d0_done, 6);
        chk("div1_y", int'(car_y), 408);
        repeat (3) @(negedge CLK);
        chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
